// File: rtl/enemy_flight_control.sv
// Flight controller for a single enemy warhead: flies from the launch point to
// the base, then sequences the shoot-down explosion, the base impact and the respawn.
module enemy_flight_control #(
  parameter int OUT_WIDTH              = 8,
  parameter int X_START                = 0,
  parameter int Y_START                = 0,
  parameter int X_BASE                 = 128,
  parameter int Y_BASE                 = 200,
  parameter int STEP_DIV               = 4,
  parameter int DESTROY_ANIMATION_TIME = 3,
  parameter int RESPAWN_DELAY          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 launch,
  input  logic                 hit,
  input  logic                 base_nuked,
  output logic [OUT_WIDTH-1:0] xenemy,
  output logic [OUT_WIDTH-1:0] yenemy,
  output logic                 enemy_active,
  output logic                 enemy_exploding,
  output logic                 impact,
  output logic [7:0]           kill_count
);

  localparam int CNT_W = 16;

  localparam logic [OUT_WIDTH-1:0] XS = OUT_WIDTH'(X_START);
  localparam logic [OUT_WIDTH-1:0] YS = OUT_WIDTH'(Y_START);
  localparam logic [OUT_WIDTH-1:0] XB = OUT_WIDTH'(X_BASE);
  localparam logic [OUT_WIDTH-1:0] YB = OUT_WIDTH'(Y_BASE);

  localparam logic [31:0] STEP_LIM    = STEP_DIV;
  localparam logic [31:0] ANIM_LIM    = DESTROY_ANIMATION_TIME;
  localparam logic [31:0] RESPAWN_LIM = RESPAWN_DELAY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLY,
    S_EXPLODE,
    S_IMPACT,
    S_RESPAWN,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nx;
  logic                   entry;
  logic [OUT_WIDTH-1:0]   x_nx;
  logic [OUT_WIDTH-1:0]   y_nx;
  logic [7:0]             kill_nx;
  logic                   tick_ok;
  logic [31:0]            cnt_inc;

  // The first cycle spent in any state never counts a frame_tick.
  assign tick_ok = frame_tick & ~entry;
  assign cnt_inc = 32'(cnt) + 32'd1;

  function automatic logic [OUT_WIDTH-1:0] step_towards(
    input logic [OUT_WIDTH-1:0] cur,
    input logic [OUT_WIDTH-1:0] tgt
  );
    if (cur < tgt) begin
      return cur + OUT_WIDTH'(1);
    end else if (cur > tgt) begin
      return cur - OUT_WIDTH'(1);
    end else begin
      return cur;
    end
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    x_nx     = xenemy;
    y_nx     = yenemy;
    kill_nx  = kill_count;

    case (state)
      S_IDLE: begin
        if (launch) begin
          state_nx = S_FLY;
          x_nx     = XS;
          y_nx     = YS;
        end
      end

      S_FLY: begin
        if (base_nuked) begin
          state_nx = S_IMPACT;
        end else if (hit) begin
          state_nx = S_EXPLODE;
          if (kill_count != 8'hFF) begin
            kill_nx = kill_count + 8'd1;
          end
        end else if (tick_ok) begin
          if (cnt_inc >= STEP_LIM) begin
            cnt_nx = '0;
            x_nx   = step_towards(xenemy, XB);
            y_nx   = step_towards(yenemy, YB);
          end else begin
            cnt_nx = CNT_W'(cnt_inc);
          end
        end
      end

      S_EXPLODE: begin
        if (tick_ok) begin
          if (cnt_inc >= ANIM_LIM) begin
            state_nx = S_RESPAWN;
            x_nx     = XS;
            y_nx     = YS;
          end else begin
            cnt_nx = CNT_W'(cnt_inc);
          end
        end
      end

      S_RESPAWN: begin
        if (tick_ok) begin
          if (cnt_inc >= RESPAWN_LIM) begin
            state_nx = S_IDLE;
          end else begin
            cnt_nx = CNT_W'(cnt_inc);
          end
        end
      end

      S_IMPACT: begin
        if (tick_ok) begin
          if (cnt_inc >= ANIM_LIM) begin
            state_nx = S_DONE;
          end else begin
            cnt_nx = CNT_W'(cnt_inc);
          end
        end
      end

      S_DONE: begin
        state_nx = S_DONE;
      end

      default: begin
        state_nx = S_IDLE;
        x_nx     = XS;
        y_nx     = YS;
      end
    endcase

    if (state_nx != state) begin
      cnt_nx = '0;
    end
  end

  // Status flags are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      entry           <= 1'b0;
      xenemy          <= XS;
      yenemy          <= YS;
      kill_count      <= 8'd0;
      enemy_active    <= 1'b0;
      enemy_exploding <= 1'b0;
      impact          <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      entry           <= (state_nx != state);
      xenemy          <= x_nx;
      yenemy          <= y_nx;
      kill_count      <= kill_nx;
      enemy_active    <= (state_nx == S_FLY);
      enemy_exploding <= (state_nx == S_EXPLODE);
      impact          <= (state_nx == S_IMPACT) || (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_enemy_flight_control.sv
// Scoreboard bench for enemy_flight_control: randomized frame ticks and noise,
// expected outputs from a behavioural flight model, checked by a separate monitor.
module tb_enemy_flight_control;

  localparam int W   = 8;
  localparam int XS  = 0;
  localparam int YS  = 50;
  localparam int XB  = 48;
  localparam int YB  = 30;
  localparam int SD  = 4;
  localparam int DAT = 3;
  localparam int RD  = 8;

  localparam int M_IDLE    = 0;
  localparam int M_FLY     = 1;
  localparam int M_EXPLODE = 2;
  localparam int M_IMPACT  = 3;
  localparam int M_RESPAWN = 4;
  localparam int M_DONE    = 5;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         frame_tick = 1'b0;
  logic         launch     = 1'b0;
  logic         hit        = 1'b0;
  logic         base_nuked = 1'b0;
  logic [W-1:0] xenemy;
  logic [W-1:0] yenemy;
  logic         enemy_active;
  logic         enemy_exploding;
  logic         impact;
  logic [7:0]   kill_count;

  typedef struct {
    string tag;
    int    x;
    int    y;
    bit    act;
    bit    expl;
    bit    imp;
    int    kill;
  } exp_t;

  exp_t exp_q[$];
  event check_ev;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   tick_pct = 40;

  int m_mode;
  int m_x;
  int m_y;
  int m_kill;
  int m_ticks;
  bit m_fresh;

  enemy_flight_control #(
    .OUT_WIDTH(W), .X_START(XS), .Y_START(YS), .X_BASE(XB), .Y_BASE(YB),
    .STEP_DIV(SD), .DESTROY_ANIMATION_TIME(DAT), .RESPAWN_DELAY(RD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .launch(launch),
    .hit(hit),
    .base_nuked(base_nuked),
    .xenemy(xenemy),
    .yenemy(yenemy),
    .enemy_active(enemy_active),
    .enemy_exploding(enemy_exploding),
    .impact(impact),
    .kill_count(kill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #700000;
    $display("[TB] FAIL watchdog: run did not finish, compared=%0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_x     = XS;
    m_y     = YS;
    m_kill  = 0;
    m_ticks = 0;
    m_fresh = 1'b0;
  endtask

  // One clock of game rules: ticks are counted per phase, skipping the entry cycle.
  task automatic model_cycle(input bit l, input bit h, input bit b, input bit t);
    int nm;
    bit counted;
    nm      = m_mode;
    counted = t && !m_fresh;
    if (m_mode == M_IDLE) begin
      if (l) begin
        nm  = M_FLY;
        m_x = XS;
        m_y = YS;
      end
    end else if (m_mode == M_FLY) begin
      if (b) begin
        nm = M_IMPACT;
      end else if (h) begin
        nm     = M_EXPLODE;
        m_kill = (m_kill < 255) ? m_kill + 1 : 255;
      end else if (counted) begin
        m_ticks++;
        if (m_ticks >= SD) begin
          m_ticks = 0;
          m_x     = toward(m_x, XB);
          m_y     = toward(m_y, YB);
        end
      end
    end else if (m_mode == M_EXPLODE) begin
      if (counted) begin
        m_ticks++;
        if (m_ticks >= DAT) begin
          nm  = M_RESPAWN;
          m_x = XS;
          m_y = YS;
        end
      end
    end else if (m_mode == M_RESPAWN) begin
      if (counted) begin
        m_ticks++;
        if (m_ticks >= RD) nm = M_IDLE;
      end
    end else if (m_mode == M_IMPACT) begin
      if (counted) begin
        m_ticks++;
        if (m_ticks >= DAT) nm = M_DONE;
      end
    end
    m_fresh = (nm != m_mode);
    if (m_fresh) m_ticks = 0;
    m_mode = nm;
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag  = tag;
    e.x    = m_x;
    e.y    = m_y;
    e.act  = (m_mode == M_FLY);
    e.expl = (m_mode == M_EXPLODE);
    e.imp  = (m_mode == M_IMPACT) || (m_mode == M_DONE);
    e.kill = m_kill;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit l, input bit h, input bit b);
    bit t;
    t          = ($urandom_range(0, 99) < tick_pct);
    launch     = l;
    hit        = h;
    base_nuked = b;
    frame_tick = t;
    model_cycle(l, h, b, t);
    @(posedge clk);
    #1;
    push_expect("cycle");
  endtask

  task automatic checkOutput(input exp_t e);
    n_cmp++;
    if (xenemy !== W'(e.x) || yenemy !== W'(e.y) || enemy_active !== e.act ||
        enemy_exploding !== e.expl || impact !== e.imp || kill_count !== 8'(e.kill)) begin
      n_bad++;
      $display("[TB] FAIL %s @%0t: got x=%0d y=%0d act=%b expl=%b imp=%b kill=%0d, want x=%0d y=%0d act=%b expl=%b imp=%b kill=%0d",
               e.tag, $time, xenemy, yenemy, enemy_active, enemy_exploding, impact, kill_count,
               e.x, e.y, e.act, e.expl, e.imp, e.kill);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or check_ev);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Reset lands between clock edges and is checked before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n      = 1'b0;
    launch     = 1'b0;
    hit        = 1'b0;
    base_nuked = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    #1;
    push_expect("async_reset");
    ->check_ev;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int target, input bit noise, input bit bn_level);
    int n;
    n = 0;
    while (m_mode != target && n < 3000) begin
      if (noise) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      bn_level | 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b0, 1'b0, bn_level);
      end
      n++;
    end
    if (m_mode != target) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL run_until timeout: mode=%0d, want %0d", m_mode, target);
    end
  endtask

  task automatic fly_until(input int tx, input int ty);
    int n;
    n = 0;
    while (!(m_x == tx && m_y == ty) && m_mode == M_FLY && n < 4000) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!(m_x == tx && m_y == ty)) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL fly_until timeout: pos=(%0d,%0d), want (%0d,%0d)", m_x, m_y, tx, ty);
    end
  endtask

  initial begin
    model_reset();
    #1;
    push_expect("reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] launch and reset mid-flight");
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);
    do_reset();

    $display("[TB] full flight, base impact, terminal DONE");
    applyStimulus(1'b1, 1'b0, 1'b0);
    fly_until(XB, YB);
    repeat (2 + $urandom_range(0, 6)) applyStimulus(1'b0, 1'b0, 1'b0);
    run_until(M_DONE, 1'b1, 1'b1);
    repeat (15) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_reset();

    $display("[TB] shoot-down at x=40, respawn, re-launch");
    applyStimulus(1'b1, 1'b0, 1'b0);
    fly_until(40, YB);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run_until(M_IDLE, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] simultaneous hit and base_nuked");
    applyStimulus(1'b0, 1'b1, 1'b1);
    run_until(M_DONE, 1'b1, 1'b0);
    do_reset();

    $display("[TB] kill counter saturation");
    tick_pct = 60;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      run_until(M_IDLE, 1'b1, 1'b0);
    end
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
